// File: rtl/id_disp_pkg.sv
// Shared constants, state encoding and segment patterns for the ID scroll display.
package id_disp_pkg;

  localparam int NUM_POS    = 4;
  localparam int MAX_DIGITS = 9;
  localparam int GAP        = 4;

  typedef enum logic {
    ST_STATIC = 1'b0,
    ST_SCROLL = 1'b1
  } state_t;

  // Active-low {a,b,c,d,e,f,g,dp}
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ERR   = 8'h61;
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;

  function automatic logic [3:0] clamp_cnt(input logic [3:0] cnt);
    return (cnt > 4'(MAX_DIGITS)) ? 4'(MAX_DIGITS) : cnt;
  endfunction

endpackage

// File: rtl/id_scroll_display_decode.sv
// Combinational digit to active-low seven-segment decoder; dp is always off here.
module ssd_decode
  import id_disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] segs
);

  always_comb begin
    segs = SEG_BLANK;
    if (!blank) begin
      case (value)
        4'd0:    segs = SEG_0;
        4'd1:    segs = SEG_1;
        4'd2:    segs = SEG_2;
        4'd3:    segs = SEG_3;
        4'd4:    segs = SEG_4;
        4'd5:    segs = SEG_5;
        4'd6:    segs = SEG_6;
        4'd7:    segs = SEG_7;
        4'd8:    segs = SEG_8;
        4'd9:    segs = SEG_9;
        default: segs = SEG_ERR;
      endcase
    end
  end

endmodule

// File: rtl/id_scroll_display.sv
// Multiplexed 4-position display of a 9-digit ID, scrolling when more than 4 digits are valid.
// Build option SCROLL_DP_EN: light dp on the position showing the oldest digit while scrolling.
//
// state     | meaning
// ST_STATIC | newest digits right-aligned, no scrolling
// ST_SCROLL | window of 4 elements starting at pos slides over digits + 4 blanks
module id_scroll_display
  import id_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] digits,
  input  logic [3:0]  digit_cnt,
  input  logic        scroll_en,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  segs
);

  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam int SCROLL_W = $clog2(SCROLL_DIV);
  localparam logic [SCAN_W-1:0]   SCAN_TC   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_TC = SCROLL_W'(SCROLL_DIV - 1);

  state_t              state_q, state_d;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [SCROLL_W-1:0] scroll_cnt, scroll_cnt_d;
  logic [1:0]          slot;
  logic [3:0]          pos, pos_d;
  logic [3:0]          cnt_q;
  logic [3:0]          n;
  logic [3:0]          buf_len;
  logic                scan_tick, scroll_tick, scroll_ok, cnt_chg;

  logic [3:0]          id_arr [16];
  logic [4:0]          elem_sum;
  logic [3:0]          elem;
  logic [3:0]          sel_idx;
  logic [3:0]          slot_digit;
  logic                slot_blank;
  logic                dp_on;
  logic [3:0]          slot_ctl;
  logic [7:0]          dec_segs;

  assign n           = clamp_cnt(digit_cnt);
  assign buf_len     = n + 4'(GAP);
  assign scan_tick   = (scan_cnt == SCAN_TC);
  assign scroll_tick = (scroll_cnt == SCROLL_TC);
  assign scroll_ok   = scroll_en && (n > 4'd4);
  assign cnt_chg     = (n != cnt_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_STATIC;
      scan_cnt   <= '0;
      scroll_cnt <= '0;
      slot       <= 2'd0;
      pos        <= 4'd0;
      cnt_q      <= 4'd0;
      ssd_ctl    <= 4'hF;
      segs       <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      pos        <= pos_d;
      scroll_cnt <= scroll_cnt_d;
      cnt_q      <= n;
      if (scan_tick) begin
        scan_cnt <= '0;
        slot     <= slot + 2'd1;
        ssd_ctl  <= slot_ctl;
        segs     <= {dec_segs[7:1], dec_segs[0] & ~dp_on};
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

  // A count change outranks a scroll tick so the new ID always starts from its oldest digit.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos;
    scroll_cnt_d = scroll_cnt;
    case (state_q)
      ST_STATIC: begin
        scroll_cnt_d = '0;
        if (scroll_ok) begin
          state_d = ST_SCROLL;
          pos_d   = 4'd0;
        end
      end
      ST_SCROLL: begin
        if (!scroll_ok) begin
          state_d      = ST_STATIC;
          pos_d        = 4'd0;
          scroll_cnt_d = '0;
        end else if (cnt_chg) begin
          pos_d        = 4'd0;
          scroll_cnt_d = '0;
        end else if (scroll_tick) begin
          pos_d        = (pos == buf_len - 4'd1) ? 4'd0 : pos + 4'd1;
          scroll_cnt_d = '0;
        end else begin
          scroll_cnt_d = scroll_cnt + SCROLL_W'(1);
        end
      end
      default: begin
        state_d      = ST_STATIC;
        pos_d        = 4'd0;
        scroll_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    id_arr = '{default: 4'h0};
    for (int k = 0; k < MAX_DIGITS; k++) begin
      id_arr[k] = digits[4*k +: 4];
    end
  end

  always_comb begin
    elem_sum = {3'b000, slot} + {1'b0, pos};
    elem     = (elem_sum >= {1'b0, buf_len}) ? 4'(elem_sum - {1'b0, buf_len}) : elem_sum[3:0];

    if (state_q == ST_SCROLL) begin
      slot_blank = (elem >= n);
      sel_idx    = n - 4'd1 - elem;
    end else begin
      sel_idx    = {2'b00, ~slot};
      slot_blank = (sel_idx >= n);
    end
    slot_digit = id_arr[sel_idx];

`ifdef SCROLL_DP_EN
    dp_on = (state_q == ST_SCROLL) && (elem == 4'd0);
`else
    dp_on = 1'b0;
`endif

    case (slot)
      2'd0:    slot_ctl = 4'b0111;
      2'd1:    slot_ctl = 4'b1011;
      2'd2:    slot_ctl = 4'b1101;
      default: slot_ctl = 4'b1110;
    endcase
  end

  ssd_decode u_decode (
    .value (slot_digit),
    .blank (slot_blank),
    .segs  (dec_segs)
  );

endmodule

// File: tb/tb_id_scroll_display.sv
// Scoreboard bench for id_scroll_display with SCAN_DIV=2, SCROLL_DIV=16.
module tb_id_scroll_display;

  logic        clk;
  logic        rst_n;
  logic [35:0] digits;
  logic [3:0]  digit_cnt;
  logic        scroll_en;
  logic [3:0]  ssd_ctl;
  logic [7:0]  segs;

  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          frame_cnt = 0;
  int          edge_cnt  = 0;
  logic [3:0]  prev_ctl  = 4'hF;

  id_scroll_display #(.SCAN_DIV(2), .SCROLL_DIV(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .digit_cnt (digit_cnt),
    .scroll_en (scroll_en),
    .ssd_ctl   (ssd_ctl),
    .segs      (segs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 8'h03;
      4'd1: return 8'h9F;
      4'd2: return 8'h25;
      4'd3: return 8'h0D;
      4'd4: return 8'h99;
      4'd5: return 8'h49;
      4'd6: return 8'h41;
      4'd7: return 8'h1F;
      4'd8: return 8'h01;
      4'd9: return 8'h09;
      default: return 8'h61;
    endcase
  endfunction

  function automatic logic [3:0] id_at(input logic [35:0] d, input int k);
    logic [35:0] t;
    t = d >> (4 * k);
    return t[3:0];
  endfunction

  // Expected frame from the current inputs: static (right-aligned) or scroll window at pos.
  task automatic push_frame(input bit scroll, input int pos);
    int n, len, e, idx;
    logic [3:0] c;
    logic [7:0] s;
    n = (digit_cnt > 4'd9) ? 9 : int'(digit_cnt);
    len = n + 4;
    for (int j = 0; j < 4; j++) begin
      c = ~(4'b1000 >> j);
      if (!scroll) begin
        idx = 3 - j;
        s = (idx < n) ? seg_of(id_at(digits, idx)) : 8'hFF;
      end else begin
        e = (pos + j) % len;
        s = (e < n) ? seg_of(id_at(digits, n - 1 - e)) : 8'hFF;
`ifdef SCROLL_DP_EN
        if (e == 0) s[0] = 1'b0;
`endif
      end
      exp_q.push_back({c, s});
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ctl  = 4'hF;
        frame_cnt = 0;
        edge_cnt  = 0;
      end else begin
        edge_cnt++;
        if (ssd_ctl !== prev_ctl) begin
          prev_ctl = ssd_ctl;
          if (exp_q.size() > 0) begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check($sformatf("f%0d_ctl", frame_cnt), 32'(ssd_ctl), 32'(e[11:8]));
            check($sformatf("f%0d_segs_ctl%b", frame_cnt, e[11:8]), 32'(segs), 32'(e[7:0]));
          end
          if (ssd_ctl == 4'b1110) frame_cnt++;
        end
      end
    end
  end

  task automatic wait_frame(input int f);
    int b = 0;
    while (frame_cnt < f && b < 400) begin
      @(posedge clk);
      b++;
    end
    check($sformatf("sync_frame%0d", f), 32'(frame_cnt), 32'(f));
  endtask

  task automatic at_edge(input int k);
    int b = 0;
    while (edge_cnt < k && b < 1000) begin
      @(posedge clk);
      b++;
    end
    check($sformatf("sync_edge%0d", k), 32'(edge_cnt), 32'(k));
    #2;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() > 0 && b < 400) begin
      @(posedge clk);
      b++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic [35:0] d, input logic [3:0] c, input logic en);
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    digits = d;
    digit_cnt = c;
    scroll_en = en;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ctl", 32'(ssd_ctl), 32'hF);
    check("rst_segs", 32'(segs), 32'hFF);
    rst_n = 1'b1;
  endtask

  initial begin
    int fl[5];
    rst_n = 1'b0;
    digits = '0;
    digit_cnt = 4'd0;
    scroll_en = 1'b0;

    // n=3 static, then an out-of-range digit, then n=4 still static
    do_reset(36'h000000123, 4'd3, 1'b1);
    wait_frame(0);
    push_frame(1'b0, 0);
    wait_frame(1);
    #2 digits = 36'h00000012C;
    wait_frame(2);
    push_frame(1'b0, 0);
    wait_frame(3);
    #2;
    digits = 36'h000001234;
    digit_cnt = 4'd4;
    wait_frame(4);
    push_frame(1'b0, 0);

    // full scroll with digit_cnt above 9 (clamps to 9): pos 0,1,7,12 and wrap to 0
    do_reset(36'h123456789, 4'hF, 1'b1);
    fl = '{0, 2, 14, 24, 26};
    for (int i = 0; i < 5; i++) begin
      wait_frame(fl[i]);
      push_frame(1'b1, fl[i] / 2);
    end

    // count change coinciding with the pos 5 -> 6 scroll tick, then scroll_en toggling
    do_reset(36'h123456789, 4'd9, 1'b1);
    wait_frame(11);
    push_frame(1'b1, 5);
    at_edge(96);
    digit_cnt = 4'd6;
    wait_frame(12);
    push_frame(1'b1, 0);
    wait_frame(13);
    #2 scroll_en = 1'b0;
    wait_frame(14);
    push_frame(1'b0, 0);
    wait_frame(15);
    #2 scroll_en = 1'b1;
    wait_frame(16);
    push_frame(1'b1, 0);

    do_reset(36'h0, 4'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
